gamma_corrector_pwl: RTL

//  Parametrised multi-channel gamma corrector for the pixel pipe. Evaluates a runtime-loadable

---
 rtl/gamma_corrector_pwl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/gamma_corrector_pwl.sv
// gamma_corrector_pwl
//   Multi-channel piecewise-linear gamma corrector. Each channel evaluates a
//   runtime-loadable knot table. The tables are double-banked: writes go to the
//   inactive bank, and a requested bank swap takes effect on the next
//   start-of-frame beat. Streaming valid-only interface, no backpressure, fixed
//   3-cycle latency.
// Ports
//   clk, rst                   clock, async active-high reset
//   enable                     1 = correct, 0 = bypass (per beat)
//   in_valid/in_sof/in_data    input beat, packed NCH*DW, ch0 in LSBs
//   out_valid/out_sof/out_data output beat, 3 cycles after input
//   cfg_we/cfg_ch/cfg_addr/    knot write into the inactive bank;
//   cfg_data                   cfg_ch == NCH broadcasts to all channels
//   cfg_swap                   request bank swap at the next SOF beat
//   cfg_pending                swap requested, not yet applied
//   active_bank                bank used by the datapath

// One channel: both knot banks plus the 3-stage interpolation pipe.
module gamma_corrector_pwl_lane #(
   parameter int DW       = 12,
   parameter int SEG_BITS = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DW-1:0]       x,
   input  logic                en,
   input  logic                rdBank,
   input  logic                we,
   input  logic                wrBank,
   input  logic [SEG_BITS:0]   wrAddr,
   input  logic [DW-1:0]       wrData,
   output logic [DW-1:0]       y
);
   localparam int FB   = DW - SEG_BITS;
   localparam int NK   = 2**SEG_BITS + 1;
   localparam int PW   = DW + FB + 2;     // holds d*frac with sign and headroom
   localparam int MAXV = 2**DW - 1;
   localparam logic signed [PW-1:0] RND  = PW'(2**(FB-1));
   localparam logic signed [PW-1:0] MAXS = PW'(MAXV);

   function automatic logic [DW-1:0] identKnot(input int k);
      int v;
      v = k << FB;
      return DW'((v > MAXV) ? MAXV : v);
   endfunction

   logic [DW-1:0] knot [2][NK];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < 2; b++)
            for (int k = 0; k < NK; k++)
               knot[b][k] <= identKnot(k);
      end else if (we) begin
         knot[wrBank][wrAddr] <= wrData;
      end
   end

   // S1: segment lookup
   logic [SEG_BITS:0] segIdx;
   assign segIdx = {1'b0, x[DW-1:FB]};

   logic [DW-1:0] y0r, y1r, x1;
   logic [FB-1:0] fracR;
   logic          en1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y0r   <= '0;
         y1r   <= '0;
         x1    <= '0;
         fracR <= '0;
         en1   <= 1'b0;
      end else begin
         y0r   <= knot[rdBank][segIdx];
         y1r   <= knot[rdBank][segIdx + 1'b1];
         x1    <= x;
         fracR <= x[FB-1:0];
         en1   <= en;
      end
   end

   // S2: signed slope times fraction, rounded, arithmetic shift
   logic signed [DW:0]   d;
   logic signed [PW-1:0] prod, pRnd;
   assign d    = $signed({1'b0, y1r}) - $signed({1'b0, y0r});
   assign prod = PW'(d) * PW'($signed({1'b0, fracR}));
   assign pRnd = (prod + RND) >>> FB;

   logic signed [PW-1:0] p2;
   logic [DW-1:0]        y02, x2;
   logic                 en2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p2  <= '0;
         y02 <= '0;
         x2  <= '0;
         en2 <= 1'b0;
      end else begin
         p2  <= pRnd;
         y02 <= y0r;
         x2  <= x1;
         en2 <= en1;
      end
   end

   // S3: add and clamp; bypass beats carry x through the same stages
   logic signed [PW-1:0] sum;
   logic [DW-1:0]        yClamp;
   assign sum = PW'($signed({1'b0, y02})) + p2;

   always_comb begin
      yClamp = sum[DW-1:0];
      if (sum < 0)
         yClamp = '0;
      else if (sum > MAXS)
         yClamp = DW'(MAXV);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) y <= '0;
      else     y <= en2 ? yClamp : x2;
   end
endmodule

module gamma_corrector_pwl #(
   parameter int DW       = 12,
   parameter int NCH      = 3,
   parameter int SEG_BITS = 5,
   parameter int CHW      = $clog2(NCH + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                in_valid,
   input  logic                in_sof,
   input  logic [NCH*DW-1:0]   in_data,
   output logic                out_valid,
   output logic                out_sof,
   output logic [NCH*DW-1:0]   out_data,
   input  logic                cfg_we,
   input  logic [CHW-1:0]      cfg_ch,
   input  logic [SEG_BITS:0]   cfg_addr,
   input  logic [DW-1:0]       cfg_data,
   input  logic                cfg_swap,
   output logic                cfg_pending,
   output logic                active_bank
);
   localparam int STAGES = 3;
   localparam logic [SEG_BITS:0] LASTK = (SEG_BITS+1)'(2**SEG_BITS);

   // A swap (pending or arriving this cycle) lands on the SOF beat itself,
   // so the lookup for that beat already uses the new bank.
   logic swapNow, curBank;
   assign swapNow = in_valid & in_sof & (cfg_swap | cfg_pending);
   assign curBank = active_bank ^ swapNow;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_bank <= 1'b0;
         cfg_pending <= 1'b0;
      end else if (swapNow) begin
         active_bank <= ~active_bank;
         cfg_pending <= 1'b0;
      end else if (cfg_swap) begin
         cfg_pending <= 1'b1;
      end
   end

   logic cfgOk;
   assign cfgOk = cfg_we && (cfg_addr <= LASTK) && ({1'b0, cfg_ch} <= (CHW+1)'(NCH));

   logic [STAGES-1:0] vldPipe, sofPipe;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vldPipe <= '0;
         sofPipe <= '0;
      end else begin
         vldPipe <= {vldPipe[STAGES-2:0], in_valid};
         sofPipe <= {sofPipe[STAGES-2:0], in_valid & in_sof};
      end
   end
   assign out_valid = vldPipe[STAGES-1];
   assign out_sof   = sofPipe[STAGES-1];

   logic [NCH-1:0] laneWe;
   for (genvar c = 0; c < NCH; c++) begin : gLane
      assign laneWe[c] = cfgOk && (cfg_ch == CHW'(c) || cfg_ch == CHW'(NCH));
      gamma_corrector_pwl_lane #(.DW(DW), .SEG_BITS(SEG_BITS)) uLane (
         .clk    (clk),
         .rst    (rst),
         .x      (in_data[c*DW +: DW]),
         .en     (enable),
         .rdBank (curBank),
         .we     (laneWe[c]),
         .wrBank (~curBank),
         .wrAddr (cfg_addr),
         .wrData (cfg_data),
         .y      (out_data[c*DW +: DW])
      );
   end
endmodule
